// File: rtl/ct_fcnvt_itof_norm.sv
// Three-stage 64-bit integer to binary64 converter: magnitude, leading-zero normalize, round/pack.
// Global stall freezes every stage; flush kills all in-flight valids.
module ct_fcnvt_itof_norm (
    input  logic        forever_cpuclk,
    input  logic        cpurst_b,
    input  logic        itof_vld,
    input  logic [63:0] itof_src,
    input  logic        itof_signed,
    input  logic [2:0]  itof_rm,
    input  logic        pipe_stall,
    input  logic        itof_flush,
    output logic        itof_done,
    output logic [63:0] itof_result,
    output logic        itof_nx
);

    localparam logic [2:0] RmRtz = 3'b001;
    localparam logic [2:0] RmRdn = 3'b010;
    localparam logic [2:0] RmRup = 3'b011;
    localparam logic [2:0] RmRmm = 3'b100;

    logic        accept;
    logic        s1_vld_q, s1_sign_q, s1_zero_q;
    logic [2:0]  s1_rm_q;
    logic [63:0] s1_mag_q;
    logic        s2_vld_q, s2_sign_q, s2_zero_q, s2_guard_q, s2_sticky_q;
    logic [2:0]  s2_rm_q;
    logic [51:0] s2_frac_q;
    logic [10:0] s2_exp_q;
    logic        done_q, nx_q;
    logic [63:0] result_q;

    logic        src_sign;
    logic [5:0]  lzc;
    logic [62:0] norm;
    logic [10:0] exp_d2;
    logic        inc;
    logic [52:0] frac_sum;
    logic [10:0] exp_rnd;
    logic [63:0] result_d;
    logic        nx_d;

    assign accept   = itof_vld & ~pipe_stall & ~itof_flush;
    assign src_sign = itof_signed & itof_src[63];

    // Highest set bit wins; mag==0 leaves lzc at 0, which the zero flag masks later.
    always_comb begin
        lzc = 6'd0;
        for (int i = 0; i < 64; i++) begin
            if (s1_mag_q[i]) lzc = 6'(63 - i);
        end
        norm   = 63'(s1_mag_q << lzc);
        exp_d2 = 11'(11'd1086 - {5'd0, lzc});
    end

    always_comb begin
        case (s2_rm_q)
            RmRtz:   inc = 1'b0;
            RmRdn:   inc = s2_sign_q & (s2_guard_q | s2_sticky_q);
            RmRup:   inc = ~s2_sign_q & (s2_guard_q | s2_sticky_q);
            RmRmm:   inc = s2_guard_q;
            default: inc = s2_guard_q & (s2_sticky_q | s2_frac_q[0]);
        endcase
        // A carry out means the fraction wrapped to zero; only the exponent needs bumping.
        frac_sum = {1'b0, s2_frac_q} + {52'd0, inc};
        exp_rnd  = frac_sum[52] ? (s2_exp_q + 11'd1) : s2_exp_q;
        result_d = s2_zero_q ? 64'h0 : {s2_sign_q, exp_rnd, frac_sum[51:0]};
        nx_d     = ~s2_zero_q & (s2_guard_q | s2_sticky_q);
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            s1_vld_q    <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_rm_q     <= 3'd0;
            s1_mag_q    <= 64'd0;
            s2_vld_q    <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_zero_q   <= 1'b0;
            s2_guard_q  <= 1'b0;
            s2_sticky_q <= 1'b0;
            s2_rm_q     <= 3'd0;
            s2_frac_q   <= 52'd0;
            s2_exp_q    <= 11'd0;
            done_q      <= 1'b0;
            nx_q        <= 1'b0;
            result_q    <= 64'h0;
        end else if (itof_flush) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            done_q   <= 1'b0;
        end else if (!pipe_stall) begin
            s1_vld_q <= accept;
            s2_vld_q <= s1_vld_q;
            done_q   <= s2_vld_q;
            if (accept) begin
                s1_sign_q <= src_sign;
                s1_zero_q <= (itof_src == 64'd0);
                s1_rm_q   <= itof_rm;
                s1_mag_q  <= src_sign ? (~itof_src + 64'd1) : itof_src;
            end
            if (s1_vld_q) begin
                s2_sign_q   <= s1_sign_q;
                s2_zero_q   <= s1_zero_q;
                s2_rm_q     <= s1_rm_q;
                s2_frac_q   <= norm[62:11];
                s2_guard_q  <= norm[10];
                s2_sticky_q <= |norm[9:0];
                s2_exp_q    <= exp_d2;
            end
            if (s2_vld_q) begin
                result_q <= result_d;
                nx_q     <= nx_d;
            end
        end
    end

    assign itof_done   = done_q;
    assign itof_result = result_q;
    assign itof_nx     = nx_q;

endmodule
